// File: rtl/cdb_pkg.sv
// Shared definitions for the common-data-bus arbiter: source indices, default widths,
// the buffered result layout and round-robin index helpers.
package cdb_pkg;

   localparam int CDB_TAG_W   = 5;
   localparam int CDB_DATA_W  = 32;

   localparam int SRC_SIMPLE  = 0;
   localparam int SRC_COMPLEX = 1;
   localparam int SRC_FP      = 2;
   localparam int NUM_SRC     = 3;

   typedef struct packed {
      logic [CDB_TAG_W-1:0]  tag;
      logic [CDB_DATA_W-1:0] data;
   } cdb_result_t;

   // Source index reached by stepping off positions from base, modulo NUM_SRC.
   function automatic logic [1:0] src_add(input logic [1:0] base, input int off);
      logic [2:0] s;
      s = {1'b0, base} + 3'(off);
      return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
   endfunction

   function automatic logic [1:0] next_src(input logic [1:0] i);
      return (i == 2'd2) ? 2'd0 : i + 2'd1;
   endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Small synchronous FIFO holding {tag, data} entries for one result source.
// DEPTH must be a power of two so the pointers wrap naturally.
module cdb_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 37
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);

   localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   count_reg;

   // Storage carries no reset; emptiness is tracked by the counter alone.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         unique case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign head  = mem[rd_ptr_reg];
   assign full  = (count_reg == FULL_CNT);
   assign empty = (count_reg == '0);

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter merging three FU result streams onto one registered broadcast bus.
// Optional CDB_BYPASS_EN lets an empty source's live offer go straight to the bus.
module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int FIFO_DEPTH = 2,
   parameter int TAG_W      = CDB_TAG_W,
   parameter int DATA_W     = CDB_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              simple_res_valid,
   input  logic [TAG_W-1:0]  simple_res_tag,
   input  logic [DATA_W-1:0] simple_res_data,
   output logic              simple_res_ready,
   input  logic              complex_res_valid,
   input  logic [TAG_W-1:0]  complex_res_tag,
   input  logic [DATA_W-1:0] complex_res_data,
   output logic              complex_res_ready,
   input  logic              fp_res_valid,
   input  logic [TAG_W-1:0]  fp_res_tag,
   input  logic [DATA_W-1:0] fp_res_data,
   output logic              fp_res_ready,
   output logic              wrValid,
   output logic [TAG_W-1:0]  wrTag,
   output logic [DATA_W-1:0] wrdata
);

   localparam int ENTRY_W = TAG_W + DATA_W;

   logic [NUM_SRC-1:0] in_valid, full, empty, accept, keep, req, push, pop, grant;
   logic [TAG_W-1:0]   in_tag  [NUM_SRC];
   logic [DATA_W-1:0]  in_data [NUM_SRC];
   logic [ENTRY_W-1:0] head    [NUM_SRC];

   logic              gnt_any;
   logic [1:0]        gnt_idx;
   logic [1:0]        rr_ptr_reg;
   logic [TAG_W-1:0]  sel_tag;
   logic [DATA_W-1:0] sel_data;
   logic              wr_valid_reg;
   logic [TAG_W-1:0]  wr_tag_reg;
   logic [DATA_W-1:0] wr_data_reg;

   assign in_valid[SRC_SIMPLE]  = simple_res_valid;
   assign in_valid[SRC_COMPLEX] = complex_res_valid;
   assign in_valid[SRC_FP]      = fp_res_valid;
   assign in_tag[SRC_SIMPLE]    = simple_res_tag;
   assign in_tag[SRC_COMPLEX]   = complex_res_tag;
   assign in_tag[SRC_FP]        = fp_res_tag;
   assign in_data[SRC_SIMPLE]   = simple_res_data;
   assign in_data[SRC_COMPLEX]  = complex_res_data;
   assign in_data[SRC_FP]       = fp_res_data;

   assign simple_res_ready  = ~full[SRC_SIMPLE];
   assign complex_res_ready = ~full[SRC_COMPLEX];
   assign fp_res_ready      = ~full[SRC_FP];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
         // Tag 0 completes the handshake but is dropped here.
         assign accept[gi] = in_valid[gi] & ~full[gi];
         assign keep[gi]   = accept[gi] & (in_tag[gi] != '0);
         assign pop[gi]    = grant[gi] & ~empty[gi];
`ifdef CDB_BYPASS_EN
         assign req[gi]    = ~empty[gi] | keep[gi];
         assign push[gi]   = keep[gi] & ~(grant[gi] & empty[gi]);
`else
         assign req[gi]    = ~empty[gi];
         assign push[gi]   = keep[gi];
`endif

         cdb_fifo #(
            .DEPTH (FIFO_DEPTH),
            .W     (ENTRY_W)
         ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[gi]),
            .pop   (pop[gi]),
            .wdata ({in_tag[gi], in_data[gi]}),
            .head  (head[gi]),
            .full  (full[gi]),
            .empty (empty[gi])
         );
      end
   endgenerate

   // First requester found walking forward from rr_ptr wins.
   always_comb begin
      grant   = '0;
      gnt_any = 1'b0;
      gnt_idx = rr_ptr_reg;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (!gnt_any && req[src_add(rr_ptr_reg, k)]) begin
            gnt_any = 1'b1;
            gnt_idx = src_add(rr_ptr_reg, k);
            grant[gnt_idx] = 1'b1;
         end
      end
   end

   always_comb begin
      sel_tag  = head[gnt_idx][ENTRY_W-1:DATA_W];
      sel_data = head[gnt_idx][DATA_W-1:0];
`ifdef CDB_BYPASS_EN
      if (empty[gnt_idx]) begin
         sel_tag  = in_tag[gnt_idx];
         sel_data = in_data[gnt_idx];
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr_reg   <= 2'd0;
         wr_valid_reg <= 1'b0;
         wr_tag_reg   <= '0;
         wr_data_reg  <= '0;
      end else if (gnt_any) begin
         rr_ptr_reg   <= next_src(gnt_idx);
         wr_valid_reg <= 1'b1;
         wr_tag_reg   <= sel_tag;
         wr_data_reg  <= sel_data;
      end else begin
         wr_valid_reg <= 1'b0;
         wr_tag_reg   <= '0;
         wr_data_reg  <= '0;
      end
   end

   assign wrValid = wr_valid_reg;
   assign wrTag   = wr_tag_reg;
   assign wrdata  = wr_data_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (default build, FIFO_DEPTH=2): latency, round-robin order,
// backpressure, tag-0 discard, mid-run reset and fairness under full load.
module tb_cdb_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        simple_res_valid = 1'b0, complex_res_valid = 1'b0, fp_res_valid = 1'b0;
   logic [4:0]  simple_res_tag = '0, complex_res_tag = '0, fp_res_tag = '0;
   logic [31:0] simple_res_data = '0, complex_res_data = '0, fp_res_data = '0;
   logic        simple_res_ready, complex_res_ready, fp_res_ready;
   logic        wrValid;
   logic [4:0]  wrTag;
   logic [31:0] wrdata;

   int n_pass  = 0;
   int n_total = 0;

   cdb_arbiter #(.FIFO_DEPTH(2), .TAG_W(5), .DATA_W(32)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .simple_res_valid  (simple_res_valid),
      .simple_res_tag    (simple_res_tag),
      .simple_res_data   (simple_res_data),
      .simple_res_ready  (simple_res_ready),
      .complex_res_valid (complex_res_valid),
      .complex_res_tag   (complex_res_tag),
      .complex_res_data  (complex_res_data),
      .complex_res_ready (complex_res_ready),
      .fp_res_valid      (fp_res_valid),
      .fp_res_tag        (fp_res_tag),
      .fp_res_data       (fp_res_data),
      .fp_res_ready      (fp_res_ready),
      .wrValid           (wrValid),
      .wrTag             (wrTag),
      .wrdata            (wrdata)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
   endtask

   task automatic check_bus(input string name, input logic v, input logic [4:0] t, input logic [31:0] d);
      $display("bus %s: valid=%0d tag=%0d data=0x%0h", name, wrValid, wrTag, wrdata);
      check({name, "_valid"}, 64'(wrValid), 64'(v));
      check({name, "_tag"},   64'(wrTag),   64'(t));
      check({name, "_data"},  64'(wrdata),  64'(d));
   endtask

   task automatic clear_inputs();
      simple_res_valid = 1'b0; complex_res_valid = 1'b0; fp_res_valid = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic check_ready_all(input string name);
      check({name, "_simple_rdy"},  64'(simple_res_ready),  64'd1);
      check({name, "_complex_rdy"}, 64'(complex_res_ready), 64'd1);
      check({name, "_fp_rdy"},      64'(fp_res_ready),      64'd1);
   endtask

   int cnt [3];
   int last [3];
   int max_gap;

   initial begin
      // Reset state
      clear_inputs();
      rst_n = 1'b0;
      step();
      step();
      check_bus("reset", 1'b0, 5'd0, 32'h0);
      check_ready_all("reset");
      rst_n = 1'b1;

      // Single result: two-cycle latency
      simple_res_valid = 1'b1; simple_res_tag = 5'd7; simple_res_data = 32'h0000_00AA;
      check("single_ready", 64'(simple_res_ready), 64'd1);
      step();
      clear_inputs();
      check_bus("single_e1", 1'b0, 5'd0, 32'h0);
      step();
      check_bus("single_e2", 1'b1, 5'd7, 32'hAA);
      step();
      check_bus("single_e3", 1'b0, 5'd0, 32'h0);

      // Three simultaneous offers, twice, from a fresh rr pointer
      do_reset();
      for (int r = 0; r < 2; r++) begin
         simple_res_valid  = 1'b1; simple_res_tag  = 5'(1 + 8*r); simple_res_data  = 32'h101 + r;
         complex_res_valid = 1'b1; complex_res_tag = 5'(2 + 8*r); complex_res_data = 32'h202 + r;
         fp_res_valid      = 1'b1; fp_res_tag      = 5'(3 + 8*r); fp_res_data      = 32'h303 + r;
         step();
         clear_inputs();
         check_bus("rr_push", 1'b0, 5'd0, 32'h0);
         step(); check_bus("rr_simple",  1'b1, 5'(1 + 8*r), 32'h101 + r);
         step(); check_bus("rr_complex", 1'b1, 5'(2 + 8*r), 32'h202 + r);
         step(); check_bus("rr_fp",      1'b1, 5'(3 + 8*r), 32'h303 + r);
         step(); check_bus("rr_idle",    1'b0, 5'd0, 32'h0);
      end

      // Tag 0 is accepted and dropped
      fp_res_valid = 1'b1; fp_res_tag = 5'd0; fp_res_data = 32'hDEAD;
      check("tag0_ready", 64'(fp_res_ready), 64'd1);
      step();
      clear_inputs();
      for (int i = 0; i < 3; i++) begin
         step();
         check_bus("tag0_none", 1'b0, 5'd0, 32'h0);
      end

      // Complex backpressure while fp stays busy
      do_reset();
      complex_res_valid = 1'b1; complex_res_tag = 5'd4; complex_res_data = 32'h104;
      fp_res_valid      = 1'b1; fp_res_tag      = 5'd20; fp_res_data     = 32'h120;
      step();
      check_bus("bp_e1", 1'b0, 5'd0, 32'h0);
      complex_res_tag = 5'd5; complex_res_data = 32'h105;
      fp_res_tag = 5'd21; fp_res_data = 32'h121;
      step();
      check_bus("bp_e2", 1'b1, 5'd4, 32'h104);
      check("bp_e2_fp_rdy", 64'(fp_res_ready), 64'd0);
      check("bp_e2_cx_rdy", 64'(complex_res_ready), 64'd1);
      complex_res_tag = 5'd6; complex_res_data = 32'h106;
      fp_res_tag = 5'd22; fp_res_data = 32'h122;
      step();
      check_bus("bp_e3", 1'b1, 5'd20, 32'h120);
      check("bp_e3_cx_rdy", 64'(complex_res_ready), 64'd0);
      check("bp_e3_fp_rdy", 64'(fp_res_ready), 64'd1);
      complex_res_valid = 1'b0;
      step();
      check_bus("bp_e4", 1'b1, 5'd5, 32'h105);
      check("bp_e4_fp_rdy", 64'(fp_res_ready), 64'd0);
      fp_res_tag = 5'd23; fp_res_data = 32'h123;
      step();
      check_bus("bp_e5", 1'b1, 5'd21, 32'h121);
      check("bp_e5_fp_rdy", 64'(fp_res_ready), 64'd1);
      step();
      check_bus("bp_e6", 1'b1, 5'd6, 32'h106);
      fp_res_valid = 1'b0;
      step(); check_bus("bp_e7", 1'b1, 5'd22, 32'h122);
      step(); check_bus("bp_e8", 1'b1, 5'd23, 32'h123);
      step(); check_bus("bp_e9", 1'b0, 5'd0, 32'h0);

      // Reset with buffered results discards them
      do_reset();
      simple_res_valid  = 1'b1; simple_res_tag  = 5'd12; simple_res_data  = 32'h112;
      complex_res_valid = 1'b1; complex_res_tag = 5'd13; complex_res_data = 32'h113;
      step();
      check_bus("mrst_push", 1'b0, 5'd0, 32'h0);
      rst_n = 1'b0;
      complex_res_valid = 1'b0;
      simple_res_tag = 5'd14; simple_res_data = 32'h114;
      step();
      check_bus("mrst_in", 1'b0, 5'd0, 32'h0);
      check_ready_all("mrst");
      rst_n = 1'b1;
      clear_inputs();
      for (int i = 0; i < 3; i++) begin
         step();
         check_bus("mrst_after", 1'b0, 5'd0, 32'h0);
      end

      // Saturated load: strict rotation, 10 grants each over 30 cycles
      do_reset();
      simple_res_valid  = 1'b1; simple_res_tag  = 5'd1; simple_res_data  = 32'h1;
      complex_res_valid = 1'b1; complex_res_tag = 5'd2; complex_res_data = 32'h2;
      fp_res_valid      = 1'b1; fp_res_tag      = 5'd3; fp_res_data      = 32'h3;
      step();
      check_bus("load_push", 1'b0, 5'd0, 32'h0);
      for (int s = 0; s < 3; s++) begin
         cnt[s]  = 0;
         last[s] = -1;
      end
      max_gap = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         check_bus("load", 1'b1, 5'((i % 3) + 1), 32'((i % 3) + 1));
         if (wrValid && wrTag >= 5'd1 && wrTag <= 5'd3) begin
            cnt[int'(wrTag) - 1]++;
            if (i - last[int'(wrTag) - 1] > max_gap) max_gap = i - last[int'(wrTag) - 1];
            last[int'(wrTag) - 1] = i;
         end
      end
      check("load_cnt_simple",  64'(cnt[0]), 64'd10);
      check("load_cnt_complex", 64'(cnt[1]), 64'd10);
      check("load_cnt_fp",      64'(cnt[2]), 64'd10);
      check("load_max_gap_le3", 64'(max_gap <= 3), 64'd1);
      clear_inputs();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
